// File: rtl/psoc_audio_fifo.sv
// Stereo sample FIFO feeding the DAC: bus-side valid/ready writes, DAC-side read strobes,
// a held output register, fill level, low-watermark interrupt and sticky underrun status.
module psoc_audio_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 48,
  parameter int LOW_WM     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  irq_low,
  output logic                  underrun,
  output logic [7:0]            underrun_cnt,
  input  logic                  clr_underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LOW_WM_L = PW'(LOW_WM);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              do_write;
  logic              do_pop;
  logic              do_underrun;

  // Handshake: a word transfers on any edge where wr_valid && wr_ready; wr_ready never
  // looks at wr_valid, and wr_valid may be held or dropped freely while wr_ready is low.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                       (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign wr_ready    = !full && !flush;
  assign do_write    = wr_valid && wr_ready;
  assign do_pop      = rd_en && !empty && !flush;
  assign do_underrun = rd_en && empty && !flush;

  assign level   = wr_ptr - rd_ptr;
  assign irq_low = (level <= LOW_WM_L);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A new underrun in the same cycle as a clear wins, restarting the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (do_underrun) begin
      underrun <= 1'b1;
      if (clr_underrun) begin
        underrun_cnt <= 8'd1;
      end else if (underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end else if (clr_underrun) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_psoc_audio_fifo.sv
// Directed bench for psoc_audio_fifo: queue-based reference model checked every cycle,
// plus literal expectations along the test plan.
module tb_psoc_audio_fifo;

  localparam int DW     = 48;
  localparam int DEPTH  = 16;
  localparam int LOW_WM = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [4:0]    level;
  logic          irq_low;
  logic          underrun;
  logic [7:0]    underrun_cnt;
  logic          clr_underrun;

  int checks = 0;
  int errors = 0;

  psoc_audio_fifo #(.DEPTH_LOG2(4), .DATA_W(DW), .LOW_WM(LOW_WM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .level(level),
    .irq_low(irq_low), .underrun(underrun), .underrun_cnt(underrun_cnt),
    .clr_underrun(clr_underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: stored words as a queue, plus output register and underrun state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd;
  logic          m_un;
  int            m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rd  = '0;
      m_un  = 1'b0;
      m_cnt = 0;
    end else begin
      bit was_full;
      bit was_empty;
      bit ur;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      ur = 1'b0;
      if (flush) begin
        exp_q.delete();
        m_rd = '0;
      end else begin
        if (rd_en && !was_empty) m_rd = exp_q.pop_front();
        if (rd_en && was_empty) ur = 1'b1;
        if (wr_valid && !was_full) exp_q.push_back(wr_data);
      end
      if (ur) begin
        m_un  = 1'b1;
        m_cnt = clr_underrun ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end else if (clr_underrun) begin
        m_un  = 1'b0;
        m_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_level", 64'(level), 64'(exp_q.size()));
      chk("m_wr_ready", 64'(wr_ready), 64'((exp_q.size() != DEPTH) && !flush));
      chk("m_irq_low", 64'(irq_low), 64'(exp_q.size() <= LOW_WM));
      chk("m_rd_data", 64'(rd_data), 64'(m_rd));
      chk("m_underrun", 64'(underrun), 64'(m_un));
      chk("m_underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
    end
  end

  // driver: apply one cycle of inputs, then return idle 1 time unit after the edge
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit re, input bit fl,
                      input bit clr);
    wr_valid     = wv;
    wr_data      = wd;
    rd_en        = re;
    flush        = fl;
    clr_underrun = clr;
    @(posedge clk);
    #1;
    wr_valid     = 1'b0;
    wr_data      = '0;
    rd_en        = 1'b0;
    flush        = 1'b0;
    clr_underrun = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_data = '0; wr_valid = 1'b0;
    rd_en = 1'b0; clr_underrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_irq_low", 64'(irq_low), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_cnt", 64'(underrun_cnt), 64'd0);
    rst_n = 1'b1;

    // three writes, then a pop
    wr(48'h000001_000002);
    wr(48'h000003_000004);
    wr(48'h000005_000006);
    chk("t1_level", 64'(level), 64'd3);
    chk("t1_irq", 64'(irq_low), 64'd1);
    chk("t1_rd_data", 64'(rd_data), 64'd0);
    rd();
    chk("t1_pop_data", 64'(rd_data), 64'h000001_000002);
    chk("t1_pop_level", 64'(level), 64'd2);
    rd();
    rd();
    chk("t1_drain_data", 64'(rd_data), 64'h000005_000006);
    chk("t1_empty", 64'(level), 64'd0);

    // fill to full, reject 17th, pop
    for (int i = 0; i < 16; i++) wr(48'(i));
    chk("t2_wr_ready", 64'(wr_ready), 64'd0);
    chk("t2_level", 64'(level), 64'd16);
    chk("t2_irq", 64'(irq_low), 64'd0);
    wr(48'h99);
    chk("t2_reject_level", 64'(level), 64'd16);
    rd();
    chk("t2_pop_data", 64'(rd_data), 64'd0);
    chk("t2_pop_level", 64'(level), 64'd15);
    chk("t2_pop_ready", 64'(wr_ready), 64'd1);

    // full + simultaneous write/pop, then order across pointer wrap
    wr(48'd16);
    chk("t3_full", 64'(level), 64'd16);
    step(1'b1, 48'd17, 1'b1, 1'b0, 1'b0);
    chk("t3_pop_nowr_level", 64'(level), 64'd15);
    chk("t3_pop_nowr_data", 64'(rd_data), 64'd1);
    wr(48'd17);
    chk("t3_refill", 64'(level), 64'd16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("t3_order", 64'(rd_data), 64'(i + 2));
    end
    chk("t3_empty", 64'(level), 64'd0);

    // underrun repeats last sample; clear collides with a new underrun
    wr(48'hAAAAAA_555555);
    rd();
    chk("t4_data", 64'(rd_data), 64'hAAAAAA_555555);
    repeat (3) rd();
    chk("t4_hold", 64'(rd_data), 64'hAAAAAA_555555);
    chk("t4_underrun", 64'(underrun), 64'd1);
    chk("t4_cnt", 64'(underrun_cnt), 64'd3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t4_clr_set_un", 64'(underrun), 64'd1);
    chk("t4_clr_set_cnt", 64'(underrun_cnt), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t4_clr_un", 64'(underrun), 64'd0);
    chk("t4_clr_cnt", 64'(underrun_cnt), 64'd0);

    // write into empty FIFO with a strobe in the same cycle: underrun, write kept
    step(1'b1, 48'h123456_789ABC, 1'b1, 1'b0, 1'b0);
    chk("t4b_un", 64'(underrun_cnt), 64'd1);
    chk("t4b_level", 64'(level), 64'd1);
    chk("t4b_hold", 64'(rd_data), 64'hAAAAAA_555555);
    rd();
    chk("t4b_head", 64'(rd_data), 64'h123456_789ABC);

    // saturation
    for (int i = 0; i < 300; i++) rd();
    chk("t5_sat", 64'(underrun_cnt), 64'd255);

    // flush with concurrent write and strobe
    for (int i = 0; i < 5; i++) wr(48'(32'hC0 + i));
    chk("t6_level5", 64'(level), 64'd5);
    step(1'b1, 48'hDEAD, 1'b1, 1'b1, 1'b0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_rd_data", 64'(rd_data), 64'd0);
    chk("t6_un", 64'(underrun), 64'd1);
    chk("t6_cnt", 64'(underrun_cnt), 64'd255);
    @(posedge clk); #1;
    chk("t6_nowrite", 64'(level), 64'd0);

    // asynchronous reset in the middle of a write burst
    wr(48'h1); wr(48'h2); rd();
    wr_valid = 1'b1; wr_data = 48'h3;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_level", 64'(level), 64'd0);
    chk("t7_rd_data", 64'(rd_data), 64'd0);
    chk("t7_un", 64'(underrun), 64'd0);
    chk("t7_cnt", 64'(underrun_cnt), 64'd0);
    chk("t7_irq", 64'(irq_low), 64'd1);
    chk("t7_ready", 64'(wr_ready), 64'd1);
    wr_valid = 1'b0; wr_data = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t7_post_level", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
